regfile_writeback: RTL

- Integer register file that consumes the selected rd value from the write-back source mux.
- Supplies rs1/rs2 operands to the ALU, branch ALU and memory address path.
- Write-back is registered through a one-entry pending-write stage, so mux-to-array timing is broken; a bypass network keeps reads coherent.
- Also keeps a committed-write counter for debug/perf.

---
 rtl/regfile_writeback.sv | 83 ++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Integer register file with a one-entry pending-write stage and optional read bypass.
// Writes are readable one cycle later with BYPASS=1 and two with BYPASS=0; there is no backpressure and no stall.
module regfile_writeback #(
  parameter int XLEN    = 32,
  parameter bit BYPASS  = 1'b1,
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rdWriteEnable,
  input  logic [4:0]         rdAddress,
  input  logic [XLEN-1:0]    rd,
  input  logic [4:0]         rs1Address,
  input  logic [4:0]         rs2Address,
  output logic [XLEN-1:0]    rs1,
  output logic [XLEN-1:0]    rs2,
  output logic               pendingValid,
  output logic [COUNT_W-1:0] writeCount
);

  logic [XLEN-1:0]    r_regs [1:31];
  logic               r_pending_vld;
  logic [4:0]         r_pending_addr;
  logic [XLEN-1:0]    r_pending_dat;
  logic [COUNT_W-1:0] r_write_count;

  logic               w_capture;
  logic [XLEN-1:0]    w_rs1_dat;
  logic [XLEN-1:0]    w_rs2_dat;

  // x0 writes are dropped here so the pending entry never targets an unstored index.
  assign w_capture = rdWriteEnable && (rdAddress != 5'd0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_pending_vld  <= 1'b0;
      r_pending_addr <= 5'd0;
      r_pending_dat  <= '0;
      r_write_count  <= '0;
    end else begin
      r_pending_vld <= w_capture;
      if (w_capture) begin
        r_pending_addr <= rdAddress;
        r_pending_dat  <= rd;
      end
      if (r_pending_vld) begin
        r_regs[r_pending_addr] <= r_pending_dat;
        r_write_count          <= r_write_count + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    w_rs1_dat = '0;
    if (rs1Address != 5'd0) begin
      if (BYPASS && r_pending_vld && (r_pending_addr == rs1Address)) begin
        w_rs1_dat = r_pending_dat;
      end else begin
        w_rs1_dat = r_regs[rs1Address];
      end
    end
  end

  always_comb begin
    w_rs2_dat = '0;
    if (rs2Address != 5'd0) begin
      if (BYPASS && r_pending_vld && (r_pending_addr == rs2Address)) begin
        w_rs2_dat = r_pending_dat;
      end else begin
        w_rs2_dat = r_regs[rs2Address];
      end
    end
  end

  assign rs1          = w_rs1_dat;
  assign rs2          = w_rs2_dat;
  assign pendingValid = r_pending_vld;
  assign writeCount   = r_write_count;

endmodule
